// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - multi-cycle sliced AND/OR/XOR/NOR unit; optional abort input via LOGIC_UNIT_ABORT_EN
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef LOGIC_UNIT_ABORT_EN
    input  logic             abort,
`endif
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int N  = (SLICE > 0) ? (WIDTH / SLICE) : 1;
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    // Reject geometries where the operand does not split into whole slices.
    generate
        if ((WIDTH <= 0) || (SLICE <= 0) || ((WIDTH % SLICE) != 0)) begin : g_bad_geometry
            $error("logic_unit_seq: WIDTH must be >0 and a multiple of SLICE");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_partial;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_abort;
    logic [WIDTH-1:0] w_op_full;
    logic [WIDTH-1:0] w_partial_next;

`ifdef LOGIC_UNIT_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // A request is only looked at when the unit is idle or just finishing.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(N - 1));

    assign result = r_result;
    assign zero   = r_zero;
    assign busy   = (r_state == S_BUSY);
    assign done   = (r_state == S_DONE);

    // Bitwise function of the latched operands; only one slice of it is consumed per cycle.
    always_comb begin
        w_op_full = '0;
        case (r_op)
            OP_AND:  w_op_full = r_a & r_b;
            OP_OR:   w_op_full = r_a | r_b;
            OP_XOR:  w_op_full = r_a ^ r_b;
            default: w_op_full = ~(r_a | r_b);
        endcase
    end

    // Merge the slice selected by the counter into the running partial word.
    always_comb begin
        w_partial_next = r_partial;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_partial_next[k*SLICE +: SLICE] = w_op_full[k*SLICE +: SLICE];
            end
        end
    end

    // Control FSM and slice counter; abort wins over the final slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_BUSY;
                        r_cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_state <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Operand capture: inputs are frozen for the whole operation once accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= op;
            r_a  <= A;
            r_b  <= B;
        end
    end

    // Partial accumulation and publication; result/zero move only on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_partial <= '0;
            r_result  <= '0;
            r_zero    <= 1'b1;
        end else begin
            if (w_accept) begin
                r_partial <= '0;
            end else if ((r_state == S_BUSY) && !w_abort) begin
                r_partial <= w_partial_next;
                if (w_last) begin
                    r_result <= w_partial_next;
                    r_zero   <= ~|w_partial_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb/tb_logic_unit_seq.sv - scoreboard bench for logic_unit_seq (32/8 and 32/32 builds)
module tb_logic_unit_seq;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_in;
    logic [1:0]  op_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        abort_in;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;

    logic        s_start;
    logic [1:0]  s_op;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic [31:0] s_result;
    logic        s_zero;
    logic        s_busy;
    logic        s_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic [31:0] last_res = '0;
    exp_t        sb[$];

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_in),
`ifdef LOGIC_UNIT_ABORT_EN
        .abort  (abort_in),
`endif
        .op     (op_in),
        .A      (a_in),
        .B      (b_in),
        .result (result),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) u_dut_n1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (s_start),
`ifdef LOGIC_UNIT_ABORT_EN
        .abort  (1'b0),
`endif
        .op     (s_op),
        .A      (s_a),
        .B      (s_b),
        .result (s_result),
        .zero   (s_zero),
        .busy   (s_busy),
        .done   (s_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res = model(o, a, b);
        e.z   = (e.res == 32'h0);
        sb.push_back(e);
    endtask

    // Scoreboard monitor: pop at each done pulse, otherwise result must hold.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_result", result, e.res);
                    check("sb_zero", zero, e.z);
                    last_res = e.res;
                end
            end else begin
                check("result_hold", result, last_res);
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit scramble);
        @(negedge clk);
        op_in = o; a_in = a; b_in = b; start_in = 1'b1;
        push_exp(o, a, b);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_phase", busy, 1);
            check("done_early", done, 0);
            if (scramble) begin
                a_in     = $urandom;
                b_in     = $urandom;
                op_in    = 2'($urandom_range(0, 3));
                start_in = (i % 2 == 0);
            end else begin
                start_in = 1'b0;
            end
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 0);
        start_in = 1'b0;
        @(negedge clk);
        check("done_single", done, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        logic [31:0] exp3 [4];
        int          prev;
        bit          got;
        exp3[0] = 32'h0000_0000; exp3[1] = 32'hFFFF_FFFF;
        exp3[2] = 32'hFFFF_FFFF; exp3[3] = 32'h0000_0000;

        rst_n = 1'b0; start_in = 1'b0; op_in = 2'b00; a_in = '0; b_in = '0; abort_in = 1'b0;
        s_start = 1'b0; s_op = 2'b00; s_a = '0; s_b = '0;
        #12;
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        mon_en = 1'b1;

        do_op(2'b00, 32'hF0F0_1234, 32'hFF00_FFFF, 1'b0);
        check("and_const", result, 32'hF000_1234);
        check("and_zero", zero, 0);

        for (int k = 0; k < 4; k++) begin
            do_op(2'(k), 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
            check("op_const", result, exp3[k]);
            check("op_zero", zero, (exp3[k] == 32'h0));
        end

        do_op(2'b10, 32'h1234_5678, 32'h0F0F_F0F0, 1'b1);
        check("scramble_const", result, 32'h1D3B_A688);

        for (int k = 0; k < 4; k++) begin
            do_op(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
        end

        @(negedge clk);
        op_in = 2'b01; a_in = $urandom; b_in = $urandom; start_in = 1'b1;
        push_exp(op_in, a_in, b_in);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (done) got = 1'b1;
            end
            check("b2b_done_seen", got, 1);
            if (k > 0) check("b2b_period", cyc - prev, 5);
            prev = cyc;
            if (k < 3) begin
                op_in = 2'($urandom_range(0, 3)); a_in = $urandom; b_in = $urandom;
                push_exp(op_in, a_in, b_in);
            end else begin
                start_in = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end_done", done, 0);

`ifdef LOGIC_UNIT_ABORT_EN
        @(negedge clk);
        op_in = 2'b01; a_in = 32'hDEAD_BEEF; b_in = 32'h1111_0000; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, last_res);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        do_op(2'b11, 32'h0000_00FF, 32'h0000_FF00, 1'b0);
        check("post_abort", result, 32'hFFFF_0000);
`endif

        @(negedge clk);
        s_op = 2'b10; s_a = 32'hC3C3_0001; s_b = 32'h3C3C_0001; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check("n1_busy", s_busy, 1);
        check("n1_no_done", s_done, 0);
        check("n1_result_hidden", s_result, 0);
        @(negedge clk);
        check("n1_done", s_done, 1);
        check("n1_result", s_result, 32'hFFFF_0000);
        check("n1_zero", s_zero, 0);
        @(negedge clk);
        check("n1_single", s_done, 0);
        check("n1_hold", s_result, 32'hFFFF_0000);

        @(negedge clk);
        op_in = 2'b01; a_in = 32'h8000_0001; b_in = 32'h0; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_zero", zero, 1);
        check("midrst_n1_result", s_result, 0);
        sb.delete();
        last_res = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        rst_n = 1'b1;
        do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("recover", result, 32'h0000_0001);

        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
